fir_coef_pingpong_memory: RTL and testbench
===========================================

Name: fir_coef_pingpong_memory

Overview:
Parametrised double-buffered (ping-pong) coefficient memory for the FIR datapath.
- Host (CPU, Avalon-MM slave s1) reads and writes the shadow bank.
- FIR engine (read-only slave s2) reads the active bank.
- A host-requested swap takes effect only at an engine frame boundary, so the engine never sees a half-updated coefficient set.
- A hardware clear sequencer zeroes the shadow bank without CPU loops.

Parameters:
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 10, word address bits; depth per bank DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1, read latency in cycles on both ports; legal values 1 or 2.

Ports:
- clk  in  1  single clock for everything.
- reset_n  in  1  asynchronous, active-low reset.
- s1_address  in  ADDR_WIDTH  host word address (shadow bank).
- s1_chipselect  in  1  host select.
- s1_read  in  1  host read strobe.
- s1_write  in  1  host write strobe.
- s1_byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- s1_writedata  in  DATA_WIDTH  write data.
- s1_readdata  out  DATA_WIDTH  host read data.
- s1_readdatavalid  out  1  host read data qualifier.
- s1_waitrequest  out  1  host stall.
- s2_address  in  ADDR_WIDTH  engine word address (active bank).
- s2_read  in  1  engine read strobe.
- s2_readdata  out  DATA_WIDTH  engine read data.
- s2_readdatavalid  out  1  engine read data qualifier.
- swap_req  in  1  one-cycle pulse from CSR: request bank swap.
- clear_req  in  1  one-cycle pulse from CSR: zero shadow bank.
- frame_sync  in  1  one-cycle pulse from FIR engine at frame boundary.
- active_bank  out  1  index of bank currently read by s2.
- swap_pending  out  1  high while a swap is waiting for frame_sync.
- swap_done  out  1  one-cycle pulse on the cycle after the swap.

Behaviour:
- Reset values:
  - state IDLE, active_bank 0, swap_pending 0, swap_done 0.
  - Both readdatavalid 0, both readdata 0.
  - s1_waitrequest 0; clear address counter 0.
  - RAM contents are not reset.
- Reset is asynchronous assert; release is synchronous to clk.
- Shadow bank = ~active_bank. s1 accesses only the shadow bank; s2 accesses only the active bank. Each bank therefore needs exactly one write port and one read port.
- s1_waitrequest = (state != IDLE), combinational from the state register.
- s1 write:
  - Accepted when chipselect & write & ~waitrequest.
  - Byte lane i is written only if s1_byteenable[i].
- s1 read:
  - Accepted when chipselect & read & ~write & ~waitrequest.
  - If read and write are both high, the write wins and no read is issued.
- s2 read is accepted every cycle s2_read=1; it never stalls.
- Read latency: readdatavalid asserts exactly READ_LATENCY cycles after the accepted cycle, with readdata valid in the same cycle. Fully pipelined: one read per cycle sustained.
- Bank selection for a read is sampled in the accept cycle. A read issued before a swap returns old-bank data even if the swap occurs in flight.
- readdata holds its last value when valid is low.
- State machine, IDLE:
  - clear_req → CLEAR, counter = 0.
  - Otherwise swap_req → SWAP_WAIT, swap_pending = 1.
  - If clear_req and swap_req arrive in the same cycle, clear wins and swap_req is dropped.
  - frame_sync is ignored in IDLE.
- State machine, CLEAR:
  - Writes all-zero to shadow[counter]; counter increments each cycle.
  - At counter = DEPTH-1, that write completes and the next state is IDLE (DEPTH cycles total).
  - swap_req, clear_req and frame_sync are ignored. s2 is unaffected.
- State machine, SWAP_WAIT:
  - On frame_sync: active_bank toggles at that clk edge, swap_pending clears, next state is IDLE, and swap_done pulses high the following cycle.
  - swap_req and clear_req are ignored.
  - Host writes stall, so the incoming bank is coherent.
- Reset mid-operation: aborts CLEAR (partially zeroed bank stays partial) and any pending swap; active_bank returns to 0.
- No address wrap in normal access (full-width addresses). The clear counter is ADDR_WIDTH+1 bits wide to detect the end without wrap.

Decomposition:
- Package fir_mem_pkg holds:
  - the state enum (IDLE, CLEAR, SWAP_WAIT);
  - constants MAX_READ_LATENCY = 2 and MIN_READ_LATENCY = 1;
  - a function for byte-lane count.
- Sub-module fir_coef_bank: simple dual-port (1W, 1R) byte-enabled RAM with a READ_LATENCY read pipeline, instantiated twice.
- The top level muxes the write source (s1 or clear) and the read address (s1 or s2) per bank by active_bank, and runs the valid pipelines.

Test Plan:
1. Reset: assert reset_n=0 mid-traffic, release → active_bank=0, swap_pending=0, both readdatavalid=0, s1_waitrequest=0.
2. Byte enables: s1 write addr 5 = 0xDEADBEEF be=0xF, then write 0x0000AA00 be=0x2, then read addr 5 → readdata 0xDEADAAEF with readdatavalid exactly READ_LATENCY cycles after accept (test LAT=1 and 2).
3. Swap:
   - Shadow addr 3 = 0x12345678, pulse swap_req → swap_pending=1; s2 read addr 3 still returns the old active value.
   - Pulse frame_sync → active_bank=1, swap_done pulses next cycle; s2 read addr 3 → 0x12345678.
4. Stall: in SWAP_WAIT, hold s1 write addr 7 = 0xCAFEF00D → waitrequest=1 until the cycle after frame_sync. The write then lands in the new shadow bank; s2 addr 7 is unchanged.
5. Clear:
   - Pulse clear_req → waitrequest high for exactly 1024 cycles; then s1 reads of addr 0, 511, 1023 return 0, and s2 data is unchanged.
   - Also pulse clear_req and swap_req in the same cycle → no swap occurs.
6. Reset mid-clear: assert reset_n at clear cycle 100 → state IDLE, shadow addrs 0–99 read 0, addr 100 retains its prior value, active_bank=0.

Source files
------------

// File: rtl/fir_mem_pkg.sv
// Shared types and constants for the ping-pong FIR coefficient memory.
package fir_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    localparam int MAX_READ_LATENCY = 2;
    localparam int MIN_READ_LATENCY = 1;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fir_coef_pingpong_memory_bank.sv
// One coefficient bank: 1W/1R byte-enabled RAM with a pipelined read path.
module fir_coef_bank
    import fir_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [DATA_WIDTH-1:0]             rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = byte_lanes(DATA_WIDTH);
    localparam int LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                           (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                           READ_LATENCY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Stage 0 only loads on a read so the output holds otherwise; later stages just shift.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            pipe_q[0] <= mem[rd_addr];
        end
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_data = pipe_q[LAT-1];

endmodule

// File: rtl/fir_coef_pingpong_memory.sv
// Double-buffered FIR coefficient memory: host edits the shadow bank, engine reads the active bank.
// state     | meaning
// IDLE      | host access allowed, waiting for clear/swap request
// CLEAR     | sequencer writes zero to shadow[counter], host stalled
// SWAP_WAIT | swap requested, waiting for frame_sync, host stalled
module fir_coef_pingpong_memory
    import fir_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ADDR_WIDTH-1:0]             s1_address,
    input  logic                              s1_chipselect,
    input  logic                              s1_read,
    input  logic                              s1_write,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]             s1_writedata,
    output logic [DATA_WIDTH-1:0]             s1_readdata,
    output logic                              s1_readdatavalid,
    output logic                              s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]             s2_address,
    input  logic                              s2_read,
    output logic [DATA_WIDTH-1:0]             s2_readdata,
    output logic                              s2_readdatavalid,
    input  logic                              swap_req,
    input  logic                              clear_req,
    input  logic                              frame_sync,
    output logic                              active_bank,
    output logic                              swap_pending,
    output logic                              swap_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = byte_lanes(DATA_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                           (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                           READ_LATENCY;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        active_d  = active_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (swap_req) begin
                    state_d = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            SWAP_WAIT: begin
                if (frame_sync) begin
                    active_d = ~active_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s1_waitrequest = (state_q != IDLE);
    assign swap_pending   = (state_q == SWAP_WAIT);
    assign active_bank    = active_q;
    assign swap_done      = done_q;

    logic                  s1_wr_acc, s1_rd_acc, clr_wr;
    logic                  sh_wr_en;
    logic [ADDR_WIDTH-1:0] sh_wr_addr;
    logic [NB-1:0]         sh_wr_be;
    logic [DATA_WIDTH-1:0] sh_wr_data;
    logic [DATA_WIDTH-1:0] bank_rd [2];

    assign s1_wr_acc = s1_chipselect & s1_write & ~s1_waitrequest;
    assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
    assign clr_wr    = (state_q == CLEAR);

    // Host and clear sequencer share the shadow write port; they never overlap since CLEAR stalls the host.
    assign sh_wr_en   = s1_wr_acc | clr_wr;
    assign sh_wr_addr = clr_wr ? clr_cnt_q[ADDR_WIDTH-1:0] : s1_address;
    assign sh_wr_be   = clr_wr ? '1 : s1_byteenable;
    assign sh_wr_data = clr_wr ? '0 : s1_writedata;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic is_active;
        assign is_active = (active_q == 1'(g));

        fir_coef_bank #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .READ_LATENCY (LAT)
        ) u_bank (
            .clk     (clk),
            .wr_en   (sh_wr_en & ~is_active),
            .wr_addr (sh_wr_addr),
            .wr_be   (sh_wr_be),
            .wr_data (sh_wr_data),
            .rd_en   (is_active ? s2_read : s1_rd_acc),
            .rd_addr (is_active ? s2_address : s1_address),
            .rd_data (bank_rd[g])
        );
    end

    // Bank index travels with each read so a swap in flight cannot redirect returned data.
    logic [LAT-1:0] s1_vld_q, s1_sel_q, s2_vld_q, s2_sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= '0;
            s1_sel_q <= '0;
            s2_vld_q <= '0;
            s2_sel_q <= '0;
        end else begin
            s1_vld_q[0] <= s1_rd_acc;
            s1_sel_q[0] <= ~active_q;
            s2_vld_q[0] <= s2_read;
            s2_sel_q[0] <= active_q;
            for (int i = 1; i < LAT; i++) begin
                s1_vld_q[i] <= s1_vld_q[i-1];
                s1_sel_q[i] <= s1_sel_q[i-1];
                s2_vld_q[i] <= s2_vld_q[i-1];
                s2_sel_q[i] <= s2_sel_q[i-1];
            end
        end
    end

    logic [DATA_WIDTH-1:0] s1_rd_mux, s2_rd_mux, s1_hold_q, s2_hold_q;

    assign s1_readdatavalid = s1_vld_q[LAT-1];
    assign s2_readdatavalid = s2_vld_q[LAT-1];
    assign s1_rd_mux        = bank_rd[s1_sel_q[LAT-1]];
    assign s2_rd_mux        = bank_rd[s2_sel_q[LAT-1]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hold_q <= '0;
            s2_hold_q <= '0;
        end else begin
            if (s1_readdatavalid) s1_hold_q <= s1_rd_mux;
            if (s2_readdatavalid) s2_hold_q <= s2_rd_mux;
        end
    end

    assign s1_readdata = s1_readdatavalid ? s1_rd_mux : s1_hold_q;
    assign s2_readdata = s2_readdatavalid ? s2_rd_mux : s2_hold_q;

endmodule

// File: tb/tb_fir_coef_pingpong_memory.sv
// Directed bench for the ping-pong coefficient memory; runs latency-1 and latency-2 instances side by side.
module tb_fir_coef_pingpong_memory;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  s1_address = '0;
    logic        s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [3:0]  s1_byteenable = '0;
    logic [31:0] s1_writedata = '0;
    logic [9:0]  s2_address = '0;
    logic        s2_read = 1'b0;
    logic        swap_req = 1'b0, clear_req = 1'b0, frame_sync = 1'b0;

    logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
    logic        a_s1_rdv, a_s2_rdv, a_wait, a_active, a_pending, a_done;
    logic        b_s1_rdv, b_s2_rdv, b_wait, b_active, b_pending, b_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        act = 1'b0;
    logic [31:0] mdl [2][1024];
    exp_t        qa1[$], qa2[$], qb1[$], qb2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_coef_pingpong_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_rdv), .s1_waitrequest(a_wait),
        .s2_address(s2_address), .s2_read(s2_read), .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_rdv),
        .swap_req(swap_req), .clear_req(clear_req), .frame_sync(frame_sync),
        .active_bank(a_active), .swap_pending(a_pending), .swap_done(a_done)
    );

    fir_coef_pingpong_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_rdv), .s1_waitrequest(b_wait),
        .s2_address(s2_address), .s2_read(s2_read), .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_rdv),
        .swap_req(swap_req), .clear_req(clear_req), .frame_sync(frame_sync),
        .active_bank(b_active), .swap_pending(b_pending), .swap_done(b_done)
    );

    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic e_act, input logic e_pend, input logic e_wait);
        cmp1({tag, "_a_active"}, a_active, e_act);
        cmp1({tag, "_b_active"}, b_active, e_act);
        cmp1({tag, "_a_pending"}, a_pending, e_pend);
        cmp1({tag, "_b_pending"}, b_pending, e_pend);
        cmp1({tag, "_a_wait"}, a_wait, e_wait);
        cmp1({tag, "_b_wait"}, b_wait, e_wait);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_ctrl(tag, 1'b0, 1'b0, 1'b0);
        cmp1({tag, "_a_done"}, a_done, 1'b0);
        cmp1({tag, "_a_s1_rdv"}, a_s1_rdv, 1'b0);
        cmp1({tag, "_a_s2_rdv"}, a_s2_rdv, 1'b0);
        cmp1({tag, "_b_s1_rdv"}, b_s1_rdv, 1'b0);
        cmp1({tag, "_b_s2_rdv"}, b_s2_rdv, 1'b0);
        cmp32({tag, "_a_s1_rd"}, a_s1_rd, 32'h0);
        cmp32({tag, "_b_s2_rd"}, b_s2_rd, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s1(input logic [31:0] d);
        qa1.push_back('{d, cyc + 1});
        qb1.push_back('{d, cyc + 2});
    endtask

    task automatic push_s2(input logic [31:0] d);
        qa2.push_back('{d, cyc + 1});
        qb2.push_back('{d, cyc + 2});
    endtask

    task automatic host_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a;
        s1_writedata = d; s1_byteenable = be;
        while (a_wait && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) cmp1("host_write_timeout", a_wait, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mdl[!act][a][i*8 +: 8] = d[i*8 +: 8];
        end
        s1_chipselect = 1'b0; s1_write = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] a);
        s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
        push_s1(mdl[!act][a]);
        tick();
        s1_chipselect = 1'b0; s1_read = 1'b0;
    endtask

    task automatic eng_read(input logic [9:0] a);
        s2_read = 1'b1; s2_address = a;
        push_s2(mdl[act][a]);
        tick();
        s2_read = 1'b0;
    endtask

    task automatic do_clear(input bit with_eng);
        int n = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        while (a_wait && n < 1100) begin
            if (with_eng) begin
                s2_read = 1'b1;
                s2_address = 10'(n % 8);
                push_s2(mdl[act][n % 8]);
            end
            n++;
            tick();
        end
        s2_read = 1'b0;
        cmp32("clear_wait_cycles", 32'(n), 32'd1024);
        for (int i = 0; i < 1024; i++) mdl[!act][i] = 32'h0;
    endtask

    task automatic do_swap(input bit eng_in_frame, input logic [9:0] ea);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk_ctrl("swap_wait", act, 1'b1, 1'b1);
        frame_sync = 1'b1;
        if (eng_in_frame) begin
            s2_read = 1'b1; s2_address = ea;
            push_s2(mdl[act][ea]);
        end
        tick();
        frame_sync = 1'b0; s2_read = 1'b0;
        act = !act;
        chk_ctrl("swap_after", act, 1'b0, 1'b0);
        cmp1("swap_done_a", a_done, 1'b1);
        cmp1("swap_done_b", b_done, 1'b1);
        tick();
        cmp1("swap_done_end_a", a_done, 1'b0);
        cmp1("swap_done_end_b", b_done, 1'b0);
    endtask

    always @(negedge clk) begin : mon_a1
        exp_t e;
        if (reset_n && a_s1_rdv) begin
            checks++;
            assert (qa1.size() != 0) else begin errors++; $error("FAIL a_s1_unexpected: observed valid expected none"); end
            if (qa1.size() != 0) begin
                e = qa1.pop_front();
                cmp32("a_s1_data", a_s1_rd, e.data);
                cmp32("a_s1_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon_b1
        exp_t e;
        if (reset_n && b_s1_rdv) begin
            checks++;
            assert (qb1.size() != 0) else begin errors++; $error("FAIL b_s1_unexpected: observed valid expected none"); end
            if (qb1.size() != 0) begin
                e = qb1.pop_front();
                cmp32("b_s1_data", b_s1_rd, e.data);
                cmp32("b_s1_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon_a2
        exp_t e;
        if (reset_n && a_s2_rdv) begin
            checks++;
            assert (qa2.size() != 0) else begin errors++; $error("FAIL a_s2_unexpected: observed valid expected none"); end
            if (qa2.size() != 0) begin
                e = qa2.pop_front();
                cmp32("a_s2_data", a_s2_rd, e.data);
                cmp32("a_s2_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : mon_b2
        exp_t e;
        if (reset_n && b_s2_rdv) begin
            checks++;
            assert (qb2.size() != 0) else begin errors++; $error("FAIL b_s2_unexpected: observed valid expected none"); end
            if (qb2.size() != 0) begin
                e = qb2.pop_front();
                cmp32("b_s2_data", b_s2_rd, e.data);
                cmp32("b_s2_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset values
        repeat (3) tick();
        chk_reset_outputs("por");
        reset_n = 1'b1;
        tick();
        chk_reset_outputs("por_rel");

        // bring both banks to a known all-zero state
        do_clear(1'b0);
        do_swap(1'b0, 10'd0);
        do_clear(1'b0);

        // byte enables
        host_write(10'd5, 32'hDEADBEEF, 4'hF);
        host_write(10'd5, 32'h0000AA00, 4'h2);
        host_read(10'd5);
        host_read(10'd5);

        // swap at frame boundary, read in flight during the swap sees old bank
        host_write(10'd3, 32'h12345678, 4'hF);
        eng_read(10'd3);
        do_swap(1'b1, 10'd3);
        eng_read(10'd3);
        eng_read(10'd3);

        // host write stalls across the swap and lands in the new shadow bank
        host_write(10'd7, 32'h11110007, 4'hF);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 10'd7;
        s1_writedata = 32'hCAFEF00D; s1_byteenable = 4'hF;
        #1;
        chk_ctrl("stall0", act, 1'b1, 1'b1);
        tick();
        chk_ctrl("stall1", act, 1'b1, 1'b1);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        act = !act;
        chk_ctrl("stall_rel", act, 1'b0, 1'b0);
        cmp1("stall_done_a", a_done, 1'b1);
        tick();
        s1_chipselect = 1'b0; s1_write = 1'b0;
        mdl[!act][7] = 32'hCAFEF00D;
        eng_read(10'd7);
        host_read(10'd7);

        // hardware clear with engine traffic running, then clear+swap collision
        host_write(10'd0, 32'hA5A50000, 4'hF);
        host_write(10'd511, 32'hA5A501FF, 4'hF);
        host_write(10'd1023, 32'hA5A503FF, 4'hF);
        do_clear(1'b1);
        host_read(10'd0);
        host_read(10'd511);
        host_read(10'd1023);
        eng_read(10'd3);
        eng_read(10'd7);
        clear_req = 1'b1; swap_req = 1'b1;
        tick();
        clear_req = 1'b0; swap_req = 1'b0;
        chk_ctrl("clr_swap", act, 1'b0, 1'b1);
        for (int n = 0; n < 1100 && a_wait; n++) tick();
        chk_ctrl("clr_swap_end", act, 1'b0, 1'b0);
        for (int i = 0; i < 1024; i++) mdl[!act][i] = 32'h0;
        eng_read(10'd3);

        // reset in the middle of traffic
        host_read(10'd5);
        eng_read(10'd3);
        reset_n = 1'b0;
        qa1.delete(); qa2.delete(); qb1.delete(); qb2.delete();
        #1;
        chk_reset_outputs("rst_traffic");
        tick();
        tick();
        reset_n = 1'b1;
        act = 1'b0;
        tick();
        chk_reset_outputs("rst_traffic_rel");

        // reset after 100 clear cycles leaves a partially zeroed shadow bank
        host_write(10'd0, 32'h0BAD0000, 4'hF);
        host_write(10'd50, 32'h0BAD0032, 4'hF);
        host_write(10'd99, 32'h0BAD0063, 4'hF);
        host_write(10'd100, 32'h0BAD0064, 4'hF);
        host_write(10'd101, 32'h0BAD0065, 4'hF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        chk_ctrl("rst_clear", 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) mdl[1][i] = 32'h0;
        chk_ctrl("rst_clear_rel", 1'b0, 1'b0, 1'b0);
        host_read(10'd0);
        host_read(10'd50);
        host_read(10'd99);
        host_read(10'd100);
        host_read(10'd101);

        repeat (6) tick();
        cmp32("drain_a_s1", 32'(qa1.size()), 32'd0);
        cmp32("drain_b_s1", 32'(qb1.size()), 32'd0);
        cmp32("drain_a_s2", 32'(qa2.size()), 32'd0);
        cmp32("drain_b_s2", 32'(qb2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
